// File: rtl/apple_spawner_pkg.sv
// Shared constants and state encoding for the apple spawner and the draw FSM.
// Holds screen/box dimensions, LFSR seed, reset apple position and the LFSR step.
package apple_spawner_pkg;

    localparam int unsigned SCREEN_W      = 160;
    localparam int unsigned SCREEN_H      = 120;
    localparam int unsigned APPLE_W       = 6;
    localparam int unsigned APPLE_H       = 6;
    localparam int unsigned HEAD_W        = 10;
    localparam int unsigned HEAD_H        = 10;
    localparam int unsigned MAX_TRIES_DEF = 8;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [7:0]  APPLE_X0  = 8'd30;
    localparam logic [6:0]  APPLE_Y0  = 7'd30;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAMPLE = 2'd1,
        CHECK  = 2'd2,
        COMMIT = 2'd3
    } state_t;

    // Fibonacci step, taps 16,14,13,11; the all-zero state is unreachable from a nonzero seed.
    function automatic logic [15:0] lfsr_next(input logic [15:0] q);
        return {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
    endfunction

endpackage

// File: rtl/apple_spawner_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; loads seed on reset and steps every cycle.
module lfsr16
    import apple_spawner_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= seed;
        end else begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/apple_spawner.sv
// Picks a pseudo-random apple position inside the play area, avoiding the snake head,
// and holds it stable for the draw FSM between requests.
module apple_spawner
    import apple_spawner_pkg::*;
#(
    parameter int unsigned XSCREEN   = SCREEN_W,
    parameter int unsigned YSCREEN   = SCREEN_H,
    parameter int unsigned XDIM_APP  = APPLE_W,
    parameter int unsigned YDIM_APP  = APPLE_H,
    parameter int unsigned XDIM      = HEAD_W,
    parameter int unsigned YDIM      = HEAD_H,
    parameter logic [15:0] SEED      = LFSR_SEED,
    parameter int unsigned MAX_TRIES = MAX_TRIES_DEF,
    parameter logic [7:0]  XAPPLE0   = APPLE_X0,
    parameter logic [6:0]  YAPPLE0   = APPLE_Y0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic [7:0] head_x,
    input  logic [6:0] head_y,
    output logic [7:0] apple_x,
    output logic [6:0] apple_y,
    output logic       busy,
    output logic       done,
    output logic [3:0] tries
);

    localparam int unsigned SPAN_X = XSCREEN - XDIM_APP - 1;
    localparam int unsigned SPAN_Y = YSCREEN - YDIM_APP - 1;

    // A single conditional subtract only folds the full raw range when 2*SPAN covers it.
    if ((2 * SPAN_X < 256) || (2 * SPAN_Y < 128) || (SPAN_X > 255) || (SPAN_Y > 127) ||
        (MAX_TRIES < 1) || (MAX_TRIES > 15) || (SEED == 16'd0)) begin : g_param_check
        $error("apple_spawner: illegal parameter set");
    end

    logic [15:0] lfsr;
    logic        lfsr_unused;

    lfsr16 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .seed (SEED),
        .q    (lfsr)
    );

    assign lfsr_unused = lfsr[7];

    logic [7:0] raw_x;
    logic [6:0] raw_y;
    logic [7:0] fold_x;
    logic [6:0] fold_y;

    assign raw_x = lfsr[15:8];
    assign raw_y = lfsr[6:0];

    // Fold raw values into [1, SPAN] to keep one pixel clear of every edge.
    always_comb begin
        fold_x = (raw_x >= 8'(SPAN_X)) ? raw_x - 8'(SPAN_X) : raw_x;
        fold_x = fold_x + 8'd1;
        fold_y = (raw_y >= 7'(SPAN_Y)) ? raw_y - 7'(SPAN_Y) : raw_y;
        fold_y = fold_y + 7'd1;
    end

    state_t     state;
    state_t     state_n;
    logic [7:0] cand_x;
    logic [6:0] cand_y;
    logic [7:0] cand_x_n;
    logic [6:0] cand_y_n;
    logic [7:0] apple_x_n;
    logic [6:0] apple_y_n;
    logic [3:0] tries_n;
    logic [3:0] tries_inc;
    logic       busy_n;
    logic       done_n;
    logic       overlap;

    logic [8:0] cx9;
    logic [8:0] hx9;
    logic [7:0] cy8;
    logic [7:0] hy8;

    // Widened box-intersection test so the far-edge sums cannot wrap.
    always_comb begin
        cx9     = 9'(cand_x);
        hx9     = 9'(head_x);
        cy8     = 8'(cand_y);
        hy8     = 8'(head_y);
        overlap = (cx9 <= hx9 + 9'(XDIM - 1)) && (hx9 <= cx9 + 9'(XDIM_APP - 1)) &&
                  (cy8 <= hy8 + 8'(YDIM - 1)) && (hy8 <= cy8 + 8'(YDIM_APP - 1));
    end

    assign tries_inc = tries + 4'd1;

    always_comb begin
        state_n   = state;
        cand_x_n  = cand_x;
        cand_y_n  = cand_y;
        apple_x_n = apple_x;
        apple_y_n = apple_y;
        tries_n   = tries;
        case (state)
            IDLE: begin
                if (req) begin
                    state_n = SAMPLE;
                    tries_n = 4'd0;
                end
            end
            SAMPLE: begin
                cand_x_n = fold_x;
                cand_y_n = fold_y;
                state_n  = CHECK;
            end
            CHECK: begin
                tries_n = tries_inc;
                if (!overlap) begin
                    apple_x_n = cand_x;
                    apple_y_n = cand_y;
                    state_n   = COMMIT;
                end else if (tries_inc < 4'(MAX_TRIES)) begin
                    state_n = SAMPLE;
                end else begin
                    // Out of retries: fall back to the reset position even if it overlaps.
                    apple_x_n = XAPPLE0;
                    apple_y_n = YAPPLE0;
                    state_n   = COMMIT;
                end
            end
            COMMIT: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        busy_n = (state_n != IDLE);
        done_n = (state_n == COMMIT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cand_x  <= 8'd0;
            cand_y  <= 7'd0;
            apple_x <= XAPPLE0;
            apple_y <= YAPPLE0;
            tries   <= 4'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            cand_x  <= cand_x_n;
            cand_y  <= cand_y_n;
            apple_x <= apple_x_n;
            apple_y <= apple_y_n;
            tries   <= tries_n;
            busy    <= busy_n;
            done    <= done_n;
        end
    end

endmodule

// File: tb/tb_apple_spawner.sv
// Directed bench for apple_spawner: reset, single/held/ignored requests, fold boundaries,
// forced fallback on a full-screen head, and reset in the middle of a request.
module tb_apple_spawner;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       req = 1'b0;
    logic [7:0] head_x = 8'd140;
    logic [6:0] head_y = 7'd100;
    logic [7:0] apple_x;
    logic [6:0] apple_y;
    logic       busy;
    logic       done;
    logic [3:0] tries;

    logic       req_f = 1'b0;
    logic [7:0] head_x_f = 8'd0;
    logic [6:0] head_y_f = 7'd0;
    logic [7:0] apple_x_f;
    logic [6:0] apple_y_f;
    logic       busy_f;
    logic       done_f;
    logic [3:0] tries_f;

    int n_checks = 0;
    int n_fail   = 0;
    int cur_ax   = 30;
    int cur_ay   = 30;

    logic [15:0] m_lfsr;

    apple_spawner dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .head_x  (head_x),
        .head_y  (head_y),
        .apple_x (apple_x),
        .apple_y (apple_y),
        .busy    (busy),
        .done    (done),
        .tries   (tries)
    );

    apple_spawner #(.XDIM(160), .YDIM(120), .MAX_TRIES(4)) dut_f (
        .clk     (clk),
        .rst     (rst),
        .req     (req_f),
        .head_x  (head_x_f),
        .head_y  (head_y_f),
        .apple_x (apple_x_f),
        .apple_y (apple_y_f),
        .busy    (busy_f),
        .done    (done_f),
        .tries   (tries_f)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) m_lfsr <= 16'hACE1;
        else     m_lfsr <= step(m_lfsr);
    end

    // Expected outcome of a request whose cycle-0 LFSR state is s0.
    function automatic void model_req(input logic [15:0] s0, input int hx, input int hy,
                                      input int xd, input int yd, input int mt,
                                      output int ax, output int ay, output int tr, output int lat);
        logic [15:0] s;
        int rx, ry, cx, cy;
        bit ov;
        s = s0;
        for (int t = 1; t <= mt; t++) begin
            s = step(s);
            if (t > 1) s = step(s);
            rx = int'(s[15:8]);
            ry = int'(s[6:0]);
            if (rx >= 153) rx = rx - 153;
            if (ry >= 113) ry = ry - 113;
            cx = rx + 1;
            cy = ry + 1;
            ov = (cx <= hx + xd - 1) && (hx <= cx + 5) && (cy <= hy + yd - 1) && (hy <= cy + 5);
            if (!ov) begin
                ax = cx; ay = cy; tr = t; lat = 2 * t + 1;
                return;
            end
        end
        ax = 30; ay = 30; tr = mt; lat = 2 * mt + 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One request with req pulsed in cycle 0; checks timing, tries and result against the model.
    task automatic run_req(input string tag, input int hx, input int hy);
        int ax, ay, tr, lat, ndone, done_at;
        model_req(m_lfsr, hx, hy, 10, 10, 8, ax, ay, tr, lat);
        head_x = 8'(hx);
        head_y = 7'(hy);
        req = 1'b1;
        ndone = 0;
        done_at = -1;
        for (int c = 1; c <= lat + 2; c++) begin
            cyc();
            req = 1'b0;
            if (c == 1) chk({tag, "_busy_c1"}, 32'(busy), 32'd1);
            if (c == lat - 1) chk({tag, "_apple_hold"}, 32'(apple_x), 32'(cur_ax));
            if (done === 1'b1) begin
                ndone++;
                done_at = c;
            end
        end
        chk({tag, "_done_cycle"}, 32'(done_at), 32'(lat));
        chk({tag, "_done_count"}, 32'(ndone), 32'd1);
        chk({tag, "_tries"}, 32'(tries), 32'(tr));
        chk({tag, "_apple_x"}, 32'(apple_x), 32'(ax));
        chk({tag, "_apple_y"}, 32'(apple_y), 32'(ay));
        cur_ax = ax;
        cur_ay = ay;
    endtask

    // Wait until the LFSR will present the target raw value in the SAMPLE cycle, then request.
    task automatic fold_test(input string tag, input int dim, input int target,
                             input int hx, input int hy, input int expv);
        logic [15:0] s;
        int n;
        s = step(m_lfsr);
        n = 0;
        while (((dim == 0) ? int'(s[15:8]) : int'(s[6:0])) != target && n < 30000) begin
            s = step(s);
            n++;
        end
        if (n >= 30000) begin
            n_checks++;
            n_fail++;
            $error("FAIL %s_search: observed no match expected raw %0d", tag, target);
        end else begin
            repeat (n) cyc();
            run_req(tag, hx, hy);
            if (dim == 0) chk({tag, "_fold"}, 32'(apple_x), 32'(expv));
            else          chk({tag, "_fold"}, 32'(apple_y), 32'(expv));
        end
    endtask

    initial begin
        int ax1, ay1, tr1, lat1, ax2, ay2, tr2, lat2, ndone, done_at, first_at;
        logic [15:0] s0, s1;

        // Reset held for three cycles
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_lfsr", 32'(dut.u_lfsr.q), 32'h0000ACE1);
        chk("rst_apple_x", 32'(apple_x), 32'd30);
        chk("rst_apple_y", 32'(apple_y), 32'd30);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_tries", 32'(tries), 32'd0);

        // Single request, then legal-area range check
        run_req("single", 140, 100);
        chk("single_x_range", 32'((apple_x >= 8'd1) && (apple_x <= 8'd153)), 32'd1);
        chk("single_y_range", 32'((apple_y >= 7'd1) && (apple_y <= 7'd113)), 32'd1);

        // Forced fallback on the full-screen-head instance
        req_f = 1'b1;
        ndone = 0;
        done_at = -1;
        for (int c = 1; c <= 12; c++) begin
            cyc();
            req_f = 1'b0;
            if (done_f === 1'b1) begin
                ndone++;
                done_at = c;
            end
        end
        chk("fb_done_cycle", 32'(done_at), 32'd9);
        chk("fb_done_count", 32'(ndone), 32'd1);
        chk("fb_tries", 32'(tries_f), 32'd4);
        chk("fb_apple_x", 32'(apple_x_f), 32'd30);
        chk("fb_apple_y", 32'(apple_y_f), 32'd30);

        // Fold boundaries
        fold_test("fold_x153", 0, 153, 140, 50, 1);
        fold_test("fold_x152", 0, 152, 10, 50, 153);
        fold_test("fold_x255", 0, 255, 10, 50, 103);
        fold_test("fold_y113", 1, 113, 50, 100, 1);
        fold_test("fold_y112", 1, 112, 50, 10, 113);
        fold_test("fold_y127", 1, 127, 50, 100, 15);

        // req pulses in cycle 0 and cycle 2: second one lands while busy
        cyc();
        model_req(m_lfsr, 140, 100, 10, 10, 8, ax1, ay1, tr1, lat1);
        head_x = 8'd140;
        head_y = 7'd100;
        req = 1'b1;
        ndone = 0;
        done_at = -1;
        for (int c = 1; c <= lat1 + 4; c++) begin
            cyc();
            req = (c == 2);
            if (done === 1'b1) begin
                ndone++;
                done_at = c;
            end
        end
        chk("ign_done_count", 32'(ndone), 32'd1);
        chk("ign_done_cycle", 32'(done_at), 32'(lat1));
        chk("ign_apple_x", 32'(apple_x), 32'(ax1));
        cur_ax = ax1;
        cur_ay = ay1;

        // req held high: re-accepted on the IDLE cycle after COMMIT
        s0 = m_lfsr;
        model_req(s0, 140, 100, 10, 10, 8, ax1, ay1, tr1, lat1);
        s1 = s0;
        for (int k = 0; k < lat1 + 1; k++) s1 = step(s1);
        model_req(s1, 140, 100, 10, 10, 8, ax2, ay2, tr2, lat2);
        req = 1'b1;
        ndone = 0;
        first_at = -1;
        done_at = -1;
        for (int c = 1; c <= lat1 + 1 + lat2; c++) begin
            cyc();
            if (done === 1'b1) begin
                ndone++;
                if (first_at < 0) first_at = c;
                else              done_at = c;
            end
        end
        req = 1'b0;
        repeat (2) cyc();
        chk("held_first_done", 32'(first_at), 32'(lat1));
        chk("held_second_done", 32'(done_at), 32'(lat1 + 1 + lat2));
        chk("held_done_count", 32'(ndone), 32'd2);
        chk("held_apple_x", 32'(apple_x), 32'(ax2));
        chk("held_apple_y", 32'(apple_y), 32'(ay2));
        cur_ax = ax2;
        cur_ay = ay2;

        // Reset in cycle 2 of a request
        req = 1'b1;
        cyc();
        req = 1'b0;
        cyc();
        rst = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_apple_x", 32'(apple_x), 32'd30);
        chk("midrst_apple_y", 32'(apple_y), 32'd30);
        chk("midrst_done", 32'(done), 32'd0);
        cyc();
        rst = 1'b0;
        ndone = 0;
        for (int c = 0; c < 6; c++) begin
            cyc();
            if (done === 1'b1) ndone++;
        end
        chk("midrst_no_done", 32'(ndone), 32'd0);
        cur_ax = 30;
        cur_ay = 30;
        run_req("after_rst", 140, 100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
